// File: rtl/pipelined_ripple_adder_if.sv
// Valid/ready operand and result channels of the pipelined ripple adder.
interface pipelined_ripple_adder_if #(
    parameter int WIDTH = 22
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout
    );
endinterface

// File: rtl/pipelined_ripple_adder.sv
// WIDTH-bit add/subtract split into STAGES ripple segments, one register per
// segment, with a bubble-collapsing valid/ready pipeline.
module pipelined_ripple_adder #(
    parameter int WIDTH  = 22,
    parameter int STAGES = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    pipelined_ripple_adder_if.slave bus
);
    localparam int STAGES_SAFE = (STAGES >= 1) ? STAGES : 1;
    localparam int SEG         = WIDTH / STAGES_SAFE;

    if (WIDTH < 1 || STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES_SAFE) != 0) begin : g_bad_params
        $error("pipelined_ripple_adder: illegal WIDTH/STAGES combination");
    end

    logic [STAGES-1:0] v_all;
    logic [STAGES-1:0] adv;

    // A stage may advance if it is empty or everything downstream of it advances.
    always_comb begin
        logic go;
        adv = '0;
        go  = !v_all[STAGES-1] || bus.out_ready;
        adv[STAGES-1] = go;
        for (int k = STAGES - 2; k >= 0; k--) begin
            go     = !v_all[k] || go;
            adv[k] = go;
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic             v_in;
        logic [WIDTH-1:0] a_in;
        logic [WIDTH-1:0] b_in;
        logic [WIDTH-1:0] s_in;
        logic             c_in;
        logic [WIDTH-1:0] s_d;
        logic             c_d;
        logic             v_q;
        logic             c_q;
        logic [WIDTH-1:0] s_q;

        if (k == 0) begin : g_capture
            assign v_in = bus.in_valid;
            assign a_in = bus.a;
            assign b_in = bus.sub ? ~bus.b : bus.b;
            assign c_in = bus.sub ? 1'b1 : bus.cin;
            assign s_in = '0;
        end else begin : g_chain
            assign v_in = g_stage[k-1].v_q;
            assign a_in = g_stage[k-1].g_ops.a_q;
            assign b_in = g_stage[k-1].g_ops.b_q;
            assign c_in = g_stage[k-1].c_q;
            assign s_in = g_stage[k-1].s_q;
        end

        // NOTE: blocking assignments here are deliberate; the carry must ripple
        // bit by bit within one evaluation of this combinational block.
        always_comb begin
            logic c;
            s_d = s_in;
            c   = c_in;
            for (int i = k * SEG; i < (k + 1) * SEG; i++) begin
                s_d[i] = a_in[i] ^ b_in[i] ^ c;
                c      = (a_in[i] & b_in[i]) | (c & (a_in[i] ^ b_in[i]));
            end
            c_d = c;
        end

        // NOTE: sum/carry registers are reset as well as the valid bit, so the
        // result port reads zero after reset rather than stale data.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v_q <= 1'b0;
                c_q <= 1'b0;
                s_q <= '0;
            end else if (adv[k]) begin
                v_q <= v_in;
                if (v_in) begin
                    c_q <= c_d;
                    s_q <= s_d;
                end
            end
        end

        // The final stage has no unconsumed operand bits left to carry.
        if (k < STAGES - 1) begin : g_ops
            logic [WIDTH-1:0] a_q;
            logic [WIDTH-1:0] b_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (adv[k] && v_in) begin
                    a_q <= a_in;
                    b_q <= b_in;
                end
            end
        end

        assign v_all[k] = v_q;
    end

    assign bus.in_ready  = adv[0];
    assign bus.out_valid = v_all[STAGES-1];
    assign bus.sum       = g_stage[STAGES-1].s_q;
    assign bus.cout      = g_stage[STAGES-1].c_q;
endmodule

// File: tb/tb_pipelined_ripple_adder.sv
// Scoreboard bench for pipelined_ripple_adder: main 22/2 instance plus a
// WIDTH/STAGES sweep of carry-chain latency checks.
module tb_pipelined_ripple_adder;
    localparam int W = 22;
    localparam int S = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    pipelined_ripple_adder_if #(.WIDTH(W)) m ();
    pipelined_ripple_adder #(.WIDTH(W), .STAGES(S)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (m.slave)
    );

    logic [W:0] sb[$];
    logic       rand_bp   = 1'b0;
    logic       sweep_go  = 1'b0;
    int         sweep_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: {cout, sum} from plain unsigned arithmetic.
    function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic cin, input logic sub);
        logic [63:0] t;
        logic [W-1:0] d;
        if (sub) begin
            d = a - b;
            return {a >= b, d};
        end
        t = 64'(a) + 64'(b) + 64'(cin);
        return {t[W], t[W-1:0]};
    endfunction

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin, input logic sub, output int stalls);
        logic ok;
        stalls = 0;
        ok = 1'b0;
        m.in_valid = 1'b1;
        m.a = a; m.b = b; m.cin = cin; m.sub = sub;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (m.in_ready) begin
                ok = 1'b1;
                break;
            end
            stalls++;
            @(posedge clk); #1;
        end
        check("accept_in_bound", ok, 1'b1);
        if (ok) sb.push_back(model(a, b, cin, sub));
        @(posedge clk); #1;
        m.in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int t = 0; t < 100; t++) begin
            @(posedge clk);
            if (sb.size() == 0) break;
        end
        #1;
        check("drain_empty", sb.size(), 0);
    endtask

    // Monitor: pops the scoreboard on each output handshake, checks hold stability.
    logic       held_v = 1'b0;
    logic [W:0] held;
    always @(negedge clk) begin
        if (!rst_n) begin
            held_v = 1'b0;
        end else begin
            if (held_v) begin
                check("held_out_valid", m.out_valid, 1'b1);
                check("held_stable", {m.cout, m.sum}, held);
            end
            if (m.out_valid && m.out_ready) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_output: got %0h expected none", {m.cout, m.sum});
                end else begin
                    check("result", {m.cout, m.sum}, sb.pop_front());
                end
            end
            held_v = m.out_valid && !m.out_ready;
            held   = {m.cout, m.sum};
        end
    end

    always begin
        @(posedge clk); #1;
        if (rand_bp) m.out_ready = 1'($urandom_range(0, 1));
    end

    for (genvar g = 0; g < 4; g++) begin : g_sweep
        localparam int SW = (g == 3) ? 32 : (g == 2) ? 22 : 8;
        localparam int ST = (g == 0) ? 1 : (g == 1) ? 8 : (g == 2) ? 11 : 4;

        pipelined_ripple_adder_if #(.WIDTH(SW)) s ();
        pipelined_ripple_adder #(.WIDTH(SW), .STAGES(ST)) dut_s (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (s.slave)
        );

        initial begin
            int edges;
            s.in_valid = 1'b0; s.a = '0; s.b = '0; s.cin = 1'b0; s.sub = 1'b0;
            s.out_ready = 1'b1;
            wait (sweep_go);
            @(posedge clk); #1;
            s.in_valid = 1'b1; s.a = '1; s.b = '0; s.cin = 1'b1;
            @(negedge clk);
            check($sformatf("sweep%0d_in_ready", g), s.in_ready, 1'b1);
            @(posedge clk); #1;
            s.in_valid = 1'b0;
            edges = 0;
            while (!s.out_valid && edges < ST + 4) begin
                @(posedge clk); #1;
                edges++;
            end
            check($sformatf("sweep%0d_latency_edges", g), edges + 1, ST);
            check($sformatf("sweep%0d_sum", g), s.sum, 0);
            check($sformatf("sweep%0d_cout", g), s.cout, 1'b1);
            sweep_cnt++;
        end
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int st;
        int total;
        m.in_valid = 1'b0; m.a = '0; m.b = '0; m.cin = 1'b0; m.sub = 1'b0;
        m.out_ready = 1'b1;

        repeat (3) @(posedge clk);
        #3;
        check("reset_out_valid", m.out_valid, 1'b0);
        check("reset_sum", m.sum, 0);
        check("reset_cout", m.cout, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("in_ready_after_reset", m.in_ready, 1'b1);

        // Carry ripples through every bit; result visible exactly one cycle.
        send(22'h3FFFFF, 22'd1, 1'b0, 1'b0, st);
        check("lat_capture_edge", m.out_valid, 1'b0);
        @(posedge clk); #1;
        check("lat_output_edge", m.out_valid, 1'b1);
        @(posedge clk); #1;
        check("single_cycle_valid", m.out_valid, 1'b0);

        send(22'd5, 22'd7, 1'b0, 1'b1, st);
        send(22'd7, 22'd5, 1'b1, 1'b1, st);
        drain();

        total = 0;
        repeat (100) begin
            send(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), st);
            total += st;
        end
        check("in_ready_always_high", total, 0);
        drain();

        // Backpressure: two beats fill the pipe, third must be refused.
        m.out_ready = 1'b0;
        send(W'($urandom), W'($urandom), 1'b1, 1'b0, st);
        check("bp_beat1_stalls", st, 0);
        send(W'($urandom), W'($urandom), 1'b0, 1'b1, st);
        check("bp_beat2_stalls", st, 0);
        m.in_valid = 1'b1; m.a = W'($urandom); m.b = W'($urandom);
        repeat (3) begin
            @(negedge clk);
            check("bp_full_in_ready", m.in_ready, 1'b0);
            @(posedge clk); #1;
        end
        m.in_valid = 1'b0;
        m.out_ready = 1'b1;
        drain();

        rand_bp = 1'b1;
        repeat (60) send(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), st);
        rand_bp = 1'b0;
        @(posedge clk); #1;
        m.out_ready = 1'b1;
        drain();

        // Asynchronous reset with two beats in flight.
        m.out_ready = 1'b0;
        send(W'($urandom), W'($urandom), 1'b0, 1'b0, st);
        send(W'($urandom), W'($urandom), 1'b0, 1'b0, st);
        #3;
        rst_n = 1'b0;
        #1;
        check("midreset_out_valid", m.out_valid, 1'b0);
        check("midreset_sum", m.sum, 0);
        check("midreset_cout", m.cout, 1'b0);
        sb.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        m.out_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("no_stale_after_reset", m.out_valid, 1'b0);
        send(22'h123456, 22'h0ABCDE, 1'b1, 1'b0, st);
        send(22'h000010, 22'h000020, 1'b0, 1'b1, st);
        drain();

        sweep_go = 1'b1;
        for (int t = 0; t < 200 && sweep_cnt < 4; t++) @(posedge clk);
        check("sweep_completed", sweep_cnt, 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/pipelined_ripple_adder.md
Name: pipelined_ripple_adder

Overview:
- Parametrised, pipelined successor to the flat ripple-carry adder.
- Splits a WIDTH-bit add or subtract into STAGES equal ripple segments, with one register boundary per segment.
- Accepts one operation per cycle through a valid/ready handshake and supports downstream backpressure.
- Sits between operand-producing logic and any ready/valid consumer in the arithmetic datapath.

Parameters:
- WIDTH, 22, operand and sum width in bits; must be at least 1.
- STAGES, 2, number of pipeline segments; 1 <= STAGES <= WIDTH; WIDTH % STAGES == 0, otherwise elaboration fails. SEG = WIDTH/STAGES.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand beat is valid.
- in_ready  out  1  block can accept a beat this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in; ignored when sub=1.
- sub  in  1  1 selects a - b (uses ~b with carry-in 1); 0 selects a + b + cin.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result this cycle.
- sum  out  WIDTH  result, modulo 2^WIDTH.
- cout  out  1  carry out of the MSB; for sub, 1 means no borrow (a >= b unsigned).

Behaviour:
- Reset (async assert, sync release):
  - All stage valid bits clear; out_valid=0, sum=0, cout=0.
  - in_ready=1 on the first cycle after release.
  - Reset mid-operation discards every in-flight beat; no partial result is ever presented.
- Stage k (k = 0..STAGES-1) holds:
  - a valid bit v[k];
  - a carry register;
  - completed sum bits [SEG*(k+1)-1:0];
  - the unconsumed upper operand bits.
- Stage 0 captures an input beat and adds segment 0 as a combinational SEG-bit full-adder ripple:
  - carry-in = sub ? 1 : cin;
  - b operand = sub ? ~b : b, inverted at capture for all bits.
- Stage k>0 adds segment k using the carry registered by stage k-1, then registers the new carry and the extended sum.
- Stage STAGES-1 drives sum, cout and out_valid=v[STAGES-1].
- Latency: a beat accepted at edge N appears with out_valid=1 after edge N+STAGES-1 (STAGES register boundaries, including capture).
- Advance rule (bubble-collapsing, per stage):
  - adv[STAGES-1] = !v[STAGES-1] || out_ready.
  - adv[k] = !v[k] || adv[k+1].
  - in_ready = adv[0]; in_ready is combinational from out_ready.
  - A stage loads from its predecessor when adv[k]=1. If the predecessor is empty, v[k] clears.
- Throughput: 1 beat/cycle with out_ready held high.
- Output stability: while out_valid=1 and out_ready=0, sum and cout hold stable. An input is accepted only while an internal bubble exists.
- Simultaneous events:
  - Output pop and input push in the same cycle on a full pipe is legal; every stage shifts.
  - in_valid=0 with in_ready=1 inserts a bubble.
- Data on a, b, cin and sub is don't-care when in_valid=0 and must not propagate as valid.
- STAGES=1 degenerates to a single registered ripple adder with the handshake.
- Arithmetic is unsigned modulo 2^WIDTH; overflow is reported only via cout.

Test Plan:
- WIDTH=22, STAGES=2, a=22'h3FFFFF, b=1, cin=0, sub=0, out_ready=1 -> after 2 edges: sum=0, cout=1, out_valid for exactly 1 cycle.
- sub=1, a=5, b=7 -> sum=22'h3FFFFE, cout=0. Then a=7, b=5 -> sum=2, cout=1.
- 100 back-to-back random beats with out_ready=1 -> one result per cycle, in order, each matching a+b+cin (or a-b) against a reference model; in_ready constantly 1.
- Hold out_ready=0 after 1 beat:
  - in_ready stays 1 until both stages fill, then drops to 0;
  - sum and cout stable while held.
  - Raising out_ready drains both beats in order with no loss or duplication.
- Assert rst_n=0 asynchronously mid-stream with 2 beats in flight -> out_valid=0, sum=0, cout=0 immediately. After release, no stale beat emerges and the next accepted beat computes correctly.
- Sweep WIDTH/STAGES in {8/1, 8/8, 22/11, 32/4} with carry-chain stimulus (a=all ones, b=0, cin=1) -> sum=0, cout=1, latency equal to STAGES edges.
